// File: rtl/irq_ctrl_multi_pkg.sv
// rtl/irq_ctrl_multi_pkg.sv - shared constants for the multi-source interrupt controller
package irq_ctrl_multi_pkg;

    localparam int NIRQ_MAX = 31;
    localparam int ID_W     = 5;

    localparam logic [5:0] OFF_PENDING   = 6'h00;
    localparam logic [5:0] OFF_ENABLE    = 6'h01;
    localparam logic [5:0] OFF_MODE      = 6'h02;
    localparam logic [5:0] OFF_THRESHOLD = 6'h03;
    localparam logic [5:0] OFF_CLAIM     = 6'h04;
    localparam logic [5:0] OFF_INSERVICE = 6'h05;
    localparam logic [5:0] OFF_PRIO      = 6'h10;

endpackage

// File: rtl/irq_prio_arb.sv
// rtl/irq_prio_arb.sv - combinational max-priority selector, ties go to the lowest id
module irq_prio_arb
    import irq_ctrl_multi_pkg::*;
#(
    parameter int NIRQ   = 8,
    parameter int PRIO_W = 3
) (
    input  logic [NIRQ-1:0]        eligible,
    input  logic [NIRQ*PRIO_W-1:0] prio_flat,
    output logic                   win_valid,
    output logic [ID_W-1:0]        win_id,
    output logic [PRIO_W-1:0]      win_prio
);

    logic [PRIO_W-1:0] p;

    // Strict greater-than while scanning upward keeps the lowest id on ties.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        win_prio  = '0;
        p         = '0;
        for (int i = 0; i < NIRQ; i++) begin
            p = prio_flat[i*PRIO_W +: PRIO_W];
            if (eligible[i] && (!win_valid || (p > win_prio))) begin
                win_valid = 1'b1;
                win_id    = ID_W'(i + 1);
                win_prio  = p;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl_multi.sv
// rtl/irq_ctrl_multi.sv - NIRQ-source interrupt controller with claim/complete on the IO bus
module irq_ctrl_multi
    import irq_ctrl_multi_pkg::*;
#(
    parameter int         NIRQ        = 8,
    parameter int         PRIO_W      = 3,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] BASE_ADR    = 8'hFC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            csr_meie,
    input  logic            io_we,
    input  logic [15:2]     io_wadr,
    input  logic [31:0]     io_wdata,
    input  logic            io_radr_en,
    input  logic [15:2]     io_radr,
    output logic [31:0]     io_rdata,
    output logic            g_interrupt,
    output logic [4:0]      irq_id
);

    logic [NIRQ-1:0]        sync_q [SYNC_STAGES];
    logic [NIRQ-1:0]        sync_d [SYNC_STAGES];
    logic [NIRQ-1:0]        sync_dly_q, sync_dly_d;
    logic [NIRQ-1:0]        enable_q, enable_d;
    logic [NIRQ-1:0]        mode_q, mode_d;
    logic [PRIO_W-1:0]      thr_q, thr_d;
    logic [NIRQ*PRIO_W-1:0] prio_q, prio_d;
    logic [NIRQ-1:0]        pending_q, pending_d;
    logic [NIRQ-1:0]        inservice_q, inservice_d;
    logic [31:0]            io_rdata_q, io_rdata_d;
    logic                   g_interrupt_q, g_interrupt_d;
    logic [ID_W-1:0]        irq_id_q, irq_id_d;

    logic [NIRQ-1:0]        sync_out, rise, eligible, claim_mask, complete_mask, mode_chg;
    logic                   win_valid, above_thr, wr_hit, rd_hit;
    logic [ID_W-1:0]        win_id, claim_id;
    logic [PRIO_W-1:0]      win_prio;
    logic [5:0]             woff, roff;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~sync_dly_q;
    assign wr_hit   = io_we && (io_wadr[15:8] == BASE_ADR);
    assign rd_hit   = io_radr_en && (io_radr[15:8] == BASE_ADR);
    assign woff     = io_wadr[7:2];
    assign roff     = io_radr[7:2];

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NIRQ; i++)
            eligible[i] = pending_q[i] && enable_q[i] && !inservice_q[i]
                          && (prio_q[i*PRIO_W +: PRIO_W] != '0);
    end

    irq_prio_arb #(.NIRQ(NIRQ), .PRIO_W(PRIO_W)) u_arb (
        .eligible  (eligible),
        .prio_flat (prio_q),
        .win_valid (win_valid),
        .win_id    (win_id),
        .win_prio  (win_prio)
    );

    assign above_thr = win_valid && (win_prio > thr_q);
    assign claim_id  = above_thr ? win_id : '0;

    always_comb begin
        sync_d[0] = irq_in;
        for (int s = 1; s < SYNC_STAGES; s++)
            sync_d[s] = sync_q[s-1];
        sync_dly_d = sync_out;

        enable_d      = enable_q;
        mode_d        = mode_q;
        thr_d         = thr_q;
        prio_d        = prio_q;
        claim_mask    = '0;
        complete_mask = '0;
        mode_chg      = '0;

        if (wr_hit) begin
            if (woff == OFF_ENABLE) enable_d = io_wdata[NIRQ-1:0];
            if (woff == OFF_MODE) begin
                mode_d   = io_wdata[NIRQ-1:0];
                mode_chg = mode_q ^ io_wdata[NIRQ-1:0];
            end
            if (woff == OFF_THRESHOLD) thr_d = io_wdata[PRIO_W-1:0];
            for (int i = 0; i < NIRQ; i++) begin
                if (woff == OFF_PRIO + 6'(i)) prio_d[i*PRIO_W +: PRIO_W] = io_wdata[PRIO_W-1:0];
                if (woff == OFF_CLAIM && io_wdata == 32'(i + 1)) complete_mask[i] = 1'b1;
            end
        end

        io_rdata_d = '0;
        if (rd_hit) begin
            case (roff)
                OFF_PENDING:   io_rdata_d = 32'(pending_q);
                OFF_ENABLE:    io_rdata_d = 32'(enable_q);
                OFF_MODE:      io_rdata_d = 32'(mode_q);
                OFF_THRESHOLD: io_rdata_d = 32'(thr_q);
                OFF_CLAIM:     io_rdata_d = 32'(claim_id);
                OFF_INSERVICE: io_rdata_d = 32'(inservice_q);
                default: begin
                    for (int i = 0; i < NIRQ; i++)
                        if (roff == OFF_PRIO + 6'(i)) io_rdata_d = 32'(prio_q[i*PRIO_W +: PRIO_W]);
                end
            endcase
            if (roff == OFF_CLAIM) begin
                for (int i = 0; i < NIRQ; i++)
                    if (claim_id == ID_W'(i + 1)) claim_mask[i] = 1'b1;
            end
        end

        // A claim landing on the same id as a complete leaves the channel in service.
        inservice_d = (inservice_q & ~complete_mask) | claim_mask;
        pending_d   = ((mode_q & ((pending_q & ~claim_mask) | rise))
                     | (~mode_q & sync_out & ~inservice_q)) & ~mode_chg;

        g_interrupt_d = csr_meie && above_thr;
        irq_id_d      = win_valid ? win_id : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            sync_dly_q    <= '0;
            enable_q      <= '0;
            mode_q        <= '0;
            thr_q         <= '0;
            prio_q        <= '0;
            pending_q     <= '0;
            inservice_q   <= '0;
            io_rdata_q    <= '0;
            g_interrupt_q <= 1'b0;
            irq_id_q      <= '0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
            sync_dly_q    <= sync_dly_d;
            enable_q      <= enable_d;
            mode_q        <= mode_d;
            thr_q         <= thr_d;
            prio_q        <= prio_d;
            pending_q     <= pending_d;
            inservice_q   <= inservice_d;
            io_rdata_q    <= io_rdata_d;
            g_interrupt_q <= g_interrupt_d;
            irq_id_q      <= irq_id_d;
        end
    end

    assign io_rdata    = io_rdata_q;
    assign g_interrupt = g_interrupt_q;
    assign irq_id      = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl_multi.sv
// tb/tb_irq_ctrl_multi.sv - directed-vector bench for irq_ctrl_multi
module tb_irq_ctrl_multi;

    localparam logic [5:0] R_PEND = 6'h00, R_EN = 6'h01, R_MODE = 6'h02, R_THR = 6'h03;
    localparam logic [5:0] R_CLM = 6'h04, R_INS = 6'h05, R_PRIO = 6'h10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  irq_in;
    logic        csr_meie;
    logic        io_we;
    logic [15:2] io_wadr;
    logic [31:0] io_wdata;
    logic        io_radr_en;
    logic [15:2] io_radr;
    logic [31:0] io_rdata;
    logic        g_interrupt;
    logic [4:0]  irq_id;

    int n_vec  = 0;
    int n_miss = 0;
    logic [31:0] d;

    irq_ctrl_multi dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .csr_meie(csr_meie),
        .io_we(io_we), .io_wadr(io_wadr), .io_wdata(io_wdata),
        .io_radr_en(io_radr_en), .io_radr(io_radr), .io_rdata(io_rdata),
        .g_interrupt(g_interrupt), .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0] wa(input logic [5:0] off);
        return {8'hFC, off};
    endfunction

    task automatic wr(input logic [5:0] off, input logic [31:0] v);
        io_wadr = wa(off); io_wdata = v; io_we = 1'b1;
        @(negedge clk);
        io_we = 1'b0;
    endtask

    task automatic rd(input logic [5:0] off, output logic [31:0] v);
        io_radr = wa(off); io_radr_en = 1'b1;
        @(negedge clk);
        v = io_rdata;
        io_radr_en = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; irq_in = '0; csr_meie = 1'b0; io_we = 1'b0; io_wadr = '0;
        io_wdata = '0; io_radr_en = 1'b0; io_radr = '0;
        cyc(2);
        check_eq("rst_gint", 32'(g_interrupt), 0);
        check_eq("rst_id", 32'(irq_id), 0);
        check_eq("rst_rdata", io_rdata, 0);
        rst_n = 1'b1;
        cyc(1);
        rd(R_EN, d);   check_eq("rst_enable", d, 0);
        rd(R_MODE, d); check_eq("rst_mode", d, 0);

        // 1: level ch3 latency
        wr(R_PRIO + 6'd2, 5); wr(R_EN, 32'h04); wr(R_THR, 0);
        csr_meie = 1'b1;
        irq_in[2] = 1'b1;
        cyc(3);
        check_eq("t1_gint_c3", 32'(g_interrupt), 0);
        cyc(1);
        check_eq("t1_gint_c4", 32'(g_interrupt), 1);
        check_eq("t1_id", 32'(irq_id), 3);
        rd(R_CLM, d); check_eq("t1_claim", d, 3);
        irq_in[2] = 1'b0;
        cyc(4);
        wr(R_CLM, 3);
        rd(R_INS, d); check_eq("t1_ins", d, 0);
        rd(R_PEND, d); check_eq("t1_pend", d, 0);

        // 2: priority order with tie
        wr(R_PRIO + 6'd1, 3); wr(R_PRIO + 6'd4, 6); wr(R_PRIO + 6'd6, 6); wr(R_EN, 32'h52);
        irq_in = 8'h52;
        cyc(5);
        rd(R_CLM, d); check_eq("t2_claim_a", d, 5);
        rd(R_CLM, d); check_eq("t2_claim_b", d, 7);
        rd(R_CLM, d); check_eq("t2_claim_c", d, 2);
        rd(R_INS, d); check_eq("t2_ins", d, 32'h52);
        irq_in = '0;
        cyc(4);
        wr(R_CLM, 5); wr(R_CLM, 7); wr(R_CLM, 2);
        rd(R_INS, d); check_eq("t2_ins_clr", d, 0);

        // 3: edge ch1
        wr(R_MODE, 32'h01); wr(R_PRIO + 6'd0, 2); wr(R_EN, 32'h01);
        irq_in[0] = 1'b1; cyc(1); irq_in[0] = 1'b0; cyc(10);
        irq_in[0] = 1'b1; cyc(1); irq_in[0] = 1'b0; cyc(4);
        check_eq("t3_gint", 32'(g_interrupt), 1);
        rd(R_PEND, d); check_eq("t3_pend_a", d, 1);
        rd(R_CLM, d);  check_eq("t3_claim_a", d, 1);
        rd(R_PEND, d); check_eq("t3_pend_clr", d, 0);
        wr(R_CLM, 1);
        irq_in[0] = 1'b1; cyc(1); irq_in[0] = 1'b0; cyc(4);
        irq_in[0] = 1'b1; cyc(1); irq_in[0] = 1'b0; cyc(1);
        rd(R_CLM, d);  check_eq("t3_claim_b", d, 1);
        rd(R_PEND, d); check_eq("t3_pend_kept", d, 1);
        wr(R_CLM, 1);
        rd(R_CLM, d);  check_eq("t3_claim_c", d, 1);
        wr(R_CLM, 1);
        wr(R_MODE, 0); wr(R_EN, 0);
        rd(R_PEND, d); check_eq("t3_pend_end", d, 0);

        // 4: threshold boundary
        wr(R_THR, 4); wr(R_PRIO + 6'd3, 4); wr(R_EN, 32'h08);
        irq_in = 8'h08;
        cyc(5);
        check_eq("t4_gint", 32'(g_interrupt), 0);
        rd(R_CLM, d); check_eq("t4_claim", d, 0);
        rd(R_INS, d); check_eq("t4_ins", d, 0);
        wr(R_PRIO + 6'd3, 5);
        cyc(1);
        check_eq("t4_gint_above", 32'(g_interrupt), 1);
        irq_in = '0;
        wr(R_THR, 0); wr(R_PRIO + 6'd3, 0); wr(R_EN, 0);

        // 5: complete re-raises held level source
        wr(R_PRIO + 6'd5, 3); wr(R_EN, 32'h20);
        irq_in = 8'h20;
        cyc(5);
        rd(R_CLM, d); check_eq("t5_claim", d, 6);
        cyc(1);
        check_eq("t5_gint_low", 32'(g_interrupt), 0);
        wr(R_CLM, 0); wr(R_CLM, 9);
        rd(R_INS, d); check_eq("t5_ins_bad_ids", d, 32'h20);
        wr(R_CLM, 6);
        check_eq("t5_gint_c0", 32'(g_interrupt), 0);
        cyc(1);
        check_eq("t5_gint_c1", 32'(g_interrupt), 0);
        cyc(1);
        check_eq("t5_gint_c2", 32'(g_interrupt), 1);
        check_eq("t5_id", 32'(irq_id), 6);

        // 6: async reset while channels are in service
        wr(R_PRIO + 6'd2, 2); wr(R_PRIO + 6'd7, 1); wr(R_EN, 32'hA4);
        irq_in = 8'hA4;
        cyc(5);
        rd(R_CLM, d); check_eq("t6_claim_a", d, 6);
        rd(R_CLM, d); check_eq("t6_claim_b", d, 3);
        cyc(2);
        check_eq("t6_gint", 32'(g_interrupt), 1);
        check_eq("t6_id", 32'(irq_id), 8);
        rd(R_INS, d); check_eq("t6_ins", d, 32'h24);
        io_radr = wa(R_CLM); io_radr_en = 1'b1;
        @(posedge clk); #2;
        check_eq("t6_rdata_pre", io_rdata, 8);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_gint", 32'(g_interrupt), 0);
        check_eq("t6_rst_id", 32'(irq_id), 0);
        check_eq("t6_rst_rdata", io_rdata, 0);
        @(negedge clk);
        io_radr_en = 1'b0; irq_in = '0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        rd(R_INS, d);          check_eq("t6_ins_after", d, 0);
        rd(R_EN, d);           check_eq("t6_en_after", d, 0);
        rd(R_PRIO + 6'd5, d);  check_eq("t6_prio_after", d, 0);
        check_eq("t6_gint_after", 32'(g_interrupt), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
